bitty_seq_ctrl: RTL and testbench
=================================

Name: bitty_seq_ctrl

Overview:
Parametrised fetch/execute sequencer for the Bitty processor top level. It owns the PC-enable, core-run, UART-ownership and stop-for-rw controls. It adds features the fixed 4-bit sequencer lacks:
- configurable decode wait states;
- halt and single-step debug mode;
- PC breakpoint;
- execute watchdog with fault state;
- retired-instruction counter.

It sits between the fetch unit, PC, Bitty core and UART TX mux.

Parameters:
ADDR_W, 8, PC/address width
INSTR_W, 16, instruction width (minimum 2)
DEC_CYC, 2, decode wait cycles between fetch_done and pc_en (1..15)
WDOG_W, 8, watchdog counter width; timeout = 2^WDOG_W-1 cycles
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
fetch_done  in  1  1-cycle pulse: instruction valid on instr
instr  in  INSTR_W  fetched instruction, stable from fetch_done until next fetch
pc  in  ADDR_W  current PC value (from PC register)
exec_done  in  1  core completion pulse
halt_req  in  1  level: enter/stay in debug halt
step  in  1  1-cycle pulse: execute one instruction while halted
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint PC
fault_clr  in  1  pulse: leave FAULT
fetch_en  out  1  permits fetch unit to run (stop_for_rw inverse is separate)
pc_en  out  1  1-cycle PC update strobe
run  out  1  1-cycle core start pulse
uart_sel  out  1  0 = fetch owns TX, 1 = core owns TX
stop_for_rw  out  1  freezes fetch unit during core I/O
halted  out  1  in HALT state
fault  out  1  in FAULT state
retired  out  CNT_W  count of completed instructions
state_o  out  4  current state encoding

Behaviour:
- All state is synchronous. reset==0 at any edge forces IDLE, clears counters and gives all outputs 0, including mid-instruction.
- States: IDLE=0, FETCH=1, DECODE=2, PCUPD=3, RUN=4, WAIT_ALU=5, WAIT_IO=6, HALT=7, FAULT=8. Other encodings go to IDLE.
- io_op = (instr[1:0]==2'b11).
- IDLE:
  - halt_req=1 -> HALT.
  - bp_en=1 and pc==bp_addr -> HALT. A breakpoint fires only from IDLE, i.e. before the fetch of that PC.
  - Otherwise -> FETCH.
- FETCH:
  - fetch_en=1.
  - On fetch_done -> DECODE and load the decode counter with DEC_CYC-1.
- DECODE:
  - Counts down each cycle; at 0 -> PCUPD.
  - Total DECODE occupancy is exactly DEC_CYC cycles.
- PCUPD:
  - pc_en=1 for exactly this one cycle, then -> RUN.
- RUN:
  - run=1 for one cycle.
  - -> WAIT_IO if io_op, else WAIT_ALU.
  - Clears the watchdog.
- WAIT_ALU:
  - Waits for exec_done, then -> IDLE.
- WAIT_IO:
  - uart_sel=1 and stop_for_rw=1 throughout.
  - Waits for exec_done, then -> IDLE.
- exec_done handling:
  - exec_done is observed only in WAIT_ALU/WAIT_IO and is ignored in every other state.
  - A pulse coincident with the RUN cycle is also ignored, so the core must finish no earlier than one cycle after run.
- Watchdog:
  - Increments each cycle in WAIT_ALU/WAIT_IO.
  - Reaching all-ones without exec_done -> FAULT.
  - exec_done in the same cycle as saturation wins: the instruction retires and there is no fault.
- retired:
  - Increments by 1 on each accepted exec_done.
  - Wraps modulo 2^CNT_W.
- HALT:
  - halted=1.
  - step pulse -> FETCH for one full instruction, after which IDLE re-evaluates halt_req/breakpoint.
  - A breakpoint does not re-fire on the first IDLE visit after a step from HALT, tracked by a 1-bit skip flag. Without this, stepping off a breakpoint would be impossible.
  - halt_req=0 with no step -> FETCH, subject to the same skip rule.
  - step and halt_req=0 in the same cycle behave as a single resume.
- halt_req asserted mid-instruction does not abort: the instruction completes, then IDLE -> HALT.
- FAULT:
  - fault=1; all strobes 0; uart_sel=0.
  - fault_clr -> IDLE.
  - The PC is not rolled back.
- Output defaults:
  - fetch_en=1 only in FETCH; all other strobes 0 outside the states named above.
  - All outputs are Moore (registered state decode). Latency from fetch_done to pc_en is DEC_CYC+1 cycles.

Test Plan:
1. ALU op: instr=16'h0004, fetch_done at cycle 10, DEC_CYC=2 -> pc_en at cycle 13, run at 14, exec_done at 17 -> IDLE at 18, retired=1, uart_sel never 1.
2. I/O op: instr=16'h0003 -> uart_sel=1 and stop_for_rw=1 from cycle after run until exec_done; returns to 0 in IDLE.
3. Breakpoint: bp_en=1, bp_addr=8'h05, pc=8'h05 in IDLE -> HALT, halted=1, no fetch_en. Then step -> exactly one instruction retires (retired +1), IDLE does not re-halt at 05; with pc=06 and halt_req=1 -> HALT again.
4. Watchdog: WDOG_W=4, no exec_done after run -> FAULT after 15 wait cycles, fault=1. fault_clr -> IDLE. exec_done exactly at count 15 -> no fault, retired increments.
5. Reset mid-op: assert reset=0 during WAIT_IO -> next edge state_o=0, uart_sel=0, retired=0. A stray exec_done in IDLE/DECODE is ignored.
6. Counter wrap: CNT_W=4, 16 instructions -> retired wraps 15->0.

Source files
------------

// File: rtl/bitty_seq_ctrl.sv
// bitty_seq_ctrl: fetch/decode/execute sequencer for the Bitty top level.
// It adds decode wait states, debug halt/step, a PC breakpoint and an execute watchdog.
module bitty_seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEC_CYC = 2,
  parameter int WDOG_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_done,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               exec_done,
  input  logic               halt_req,
  input  logic               step,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic               fault_clr,
  output logic               fetch_en,
  output logic               pc_en,
  output logic               run,
  output logic               uart_sel,
  output logic               stop_for_rw,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    PCUPD    = 4'd3,
    RUN      = 4'd4,
    WAIT_ALU = 4'd5,
    WAIT_IO  = 4'd6,
    HALT     = 4'd7,
    FAULT    = 4'd8
  } state_t;

  localparam logic [3:0] DEC_LD = 4'(DEC_CYC - 1);
  localparam logic [WDOG_W-1:0] WD_MAX = '1;
  localparam logic [WDOG_W-1:0] WD_LAST = WD_MAX - 1'b1;

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          dcnt_q;
  logic [3:0]          dcnt_d;
  logic [WDOG_W-1:0]   wdog_q;
  logic [WDOG_W-1:0]   wdog_d;
  logic                skip_q;
  logic                skip_d;
  logic [CNT_W-1:0]    ret_q;
  logic [CNT_W-1:0]    ret_d;

  logic io_op;
  logic bp_hit;
  logic unused_instr;

  assign io_op  = (instr[1:0] == 2'b11);
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;
  assign unused_instr = ^instr;

  // skip_q lets the PC we just stepped or resumed from get past its breakpoint once
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wdog_d  = wdog_q;
    skip_d  = skip_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (halt_req || bp_hit) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (fetch_done) begin
          state_d = DECODE;
          dcnt_d  = DEC_LD;
        end
      end
      DECODE: begin
        if (dcnt_q == 4'd0) begin
          state_d = PCUPD;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end
      PCUPD: begin
        state_d = RUN;
      end
      RUN: begin
        wdog_d  = '0;
        state_d = io_op ? WAIT_IO : WAIT_ALU;
      end
      WAIT_ALU, WAIT_IO: begin
        if (exec_done) begin
          state_d = IDLE;
          ret_d   = ret_q + 1'b1;
        end else if (wdog_q == WD_LAST) begin
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      HALT: begin
        if (step || !halt_req) begin
          state_d = FETCH;
          skip_d  = 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      wdog_q  <= '0;
      skip_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wdog_q  <= wdog_d;
      skip_q  <= skip_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    fetch_en    = 1'b0;
    pc_en       = 1'b0;
    run         = 1'b0;
    uart_sel    = 1'b0;
    stop_for_rw = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    unique case (state_q)
      FETCH:   fetch_en = 1'b1;
      PCUPD:   pc_en    = 1'b1;
      RUN:     run      = 1'b1;
      WAIT_IO: begin
        uart_sel    = 1'b1;
        stop_for_rw = 1'b1;
      end
      HALT:    halted   = 1'b1;
      FAULT:   fault    = 1'b1;
      default: begin
      end
    endcase
  end

  assign retired = ret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bitty_seq_ctrl.sv
// tb_bitty_seq_ctrl: directed plus randomized checks of the Bitty sequencer
// against a transaction-timing reference model.
module tb_bitty_seq_ctrl;

  localparam int DEC  = 2;
  localparam int WW   = 4;
  localparam int CW   = 4;
  localparam int WLIM = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_done = 1'b0;
  logic [15:0]   instr = '0;
  logic [7:0]    pc = '0;
  logic          exec_done = 1'b0;
  logic          halt_req = 1'b0;
  logic          step = 1'b0;
  logic          bp_en = 1'b0;
  logic [7:0]    bp_addr = '0;
  logic          fault_clr = 1'b0;
  logic          fetch_en;
  logic          pc_en;
  logic          run;
  logic          uart_sel;
  logic          stop_for_rw;
  logic          halted;
  logic          fault;
  logic [CW-1:0] retired;
  logic [3:0]    state_o;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  bitty_seq_ctrl #(
    .ADDR_W(8),
    .INSTR_W(16),
    .DEC_CYC(DEC),
    .WDOG_W(WW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_done(fetch_done),
    .instr(instr),
    .pc(pc),
    .exec_done(exec_done),
    .halt_req(halt_req),
    .step(step),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .fault_clr(fault_clr),
    .fetch_en(fetch_en),
    .pc_en(pc_en),
    .run(run),
    .uart_sel(uart_sel),
    .stop_for_rw(stop_for_rw),
    .halted(halted),
    .fault(fault),
    .retired(retired),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_fetch();
    tick();
    chk("to_fetch", state_o, 1);
    chk("fetch_en", fetch_en, 1);
  endtask

  // ed: wait cycle (1-based) carrying exec_done; 0 means never
  task automatic run_instr(input logic [15:0] ins, input int fw,
                           input int ed, input bit stray,
                           input bit rst_wait);
    bit io;
    int ws;
    io = (ins[1:0] == 2'b11);
    ws = io ? 6 : 5;
    repeat (fw) tick();
    chk("fetch_hold", state_o, 1);
    instr = ins;
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    exec_done = stray;
    for (int k = 0; k < DEC; k++) begin
      chk("decode", state_o, 2);
      chk("decode_pc_en", pc_en, 0);
      tick();
      exec_done = 1'b0;
    end
    chk("pc_en", pc_en, 1);
    chk("pcupd_run", run, 0);
    tick();
    chk("run", run, 1);
    chk("run_pc_en", pc_en, 0);
    chk("run_retired", retired, exp_ret);
    exec_done = stray;
    tick();
    exec_done = 1'b0;
    chk("wait_entry", state_o, ws);
    if (rst_wait) begin
      chk("rw_uart", uart_sel, io);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      exp_ret = 0;
      chk("rst_state", state_o, 0);
      chk("rst_uart", uart_sel, 0);
      chk("rst_stop", stop_for_rw, 0);
      chk("rst_retired", retired, 0);
    end else if (ed > 0) begin
      for (int w = 1; w < ed; w++) begin
        chk("wait_uart", uart_sel, io);
        chk("wait_stop", stop_for_rw, io);
        tick();
      end
      chk("wait_last", state_o, ws);
      chk("wait_last_uart", uart_sel, io);
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      exp_ret = (exp_ret + 1) % (1 << CW);
      chk("retire_idle", state_o, 0);
      chk("retired", retired, exp_ret);
      chk("idle_uart", uart_sel, 0);
      chk("idle_stop", stop_for_rw, 0);
    end else begin
      for (int w = 1; w < WLIM; w++) begin
        chk("wdog_wait", state_o, ws);
        tick();
      end
      chk("wdog_last", state_o, ws);
      tick();
      chk("fault_state", state_o, 8);
      chk("fault_flag", fault, 1);
      chk("fault_uart", uart_sel, 0);
      chk("fault_fetch", fetch_en, 0);
      chk("fault_retired", retired, exp_ret);
      tick();
      chk("fault_hold", state_o, 8);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("fault_clr", state_o, 0);
      chk("fault_clr_flag", fault, 0);
    end
  endtask

  initial begin
    logic [15:0] ins;
    int ed;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_state0", state_o, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_run", run, 0);
    chk("rst_uart0", uart_sel, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retired0", retired, 0);
    reset = 1'b1;

    to_fetch();
    run_instr(16'h0004, 0, 3, 1'b0, 1'b0);
    to_fetch();
    run_instr(16'h0003, 1, 4, 1'b1, 1'b0);

    exec_done = 1'b1;
    to_fetch();
    exec_done = 1'b0;
    chk("stray_idle", retired, exp_ret);

    run_instr(16'h0008, 0, 0, 1'b0, 1'b0);
    to_fetch();
    run_instr(16'h0004, 0, WLIM, 1'b0, 1'b0);
    to_fetch();
    run_instr(16'h0007, 0, 0, 1'b0, 1'b0);
    to_fetch();
    run_instr(16'h00f3, 2, WLIM, 1'b1, 1'b0);

    pc = 8'h05;
    bp_addr = 8'h05;
    bp_en = 1'b1;
    tick();
    chk("bp_halt", state_o, 7);
    chk("bp_halted", halted, 1);
    chk("bp_no_fetch", fetch_en, 0);
    halt_req = 1'b1;
    tick();
    chk("halt_hold", state_o, 7);
    step = 1'b1;
    halt_req = 1'b0;
    tick();
    step = 1'b0;
    chk("step_fetch", state_o, 1);
    run_instr(16'h0010, 0, 2, 1'b0, 1'b0);
    to_fetch();
    run_instr(16'h0020, 1, 1, 1'b0, 1'b0);
    tick();
    chk("bp_refire", state_o, 7);
    halt_req = 1'b1;
    tick();
    chk("halt_held", halted, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_held", state_o, 1);
    pc = 8'h06;
    run_instr(16'h0013, 0, 2, 1'b0, 1'b0);
    tick();
    chk("rehalt", state_o, 7);
    halt_req = 1'b0;
    bp_en = 1'b0;
    tick();
    chk("resume", state_o, 1);
    run_instr(16'h0100, 0, 1, 1'b0, 1'b0);

    to_fetch();
    halt_req = 1'b1;
    run_instr(16'h0001, 2, 3, 1'b0, 1'b0);
    tick();
    chk("mid_halt", state_o, 7);
    halt_req = 1'b0;
    tick();
    chk("mid_resume", state_o, 1);
    run_instr(16'h0002, 0, 2, 1'b0, 1'b0);

    to_fetch();
    run_instr(16'h0c03, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ins = 16'($urandom);
      ed = $urandom_range(0, 7);
      if (ed == 7) ed = WLIM;
      pc = 8'($urandom);
      exec_done = 1'($urandom_range(0, 1));
      to_fetch();
      exec_done = 1'b0;
      run_instr(ins, $urandom_range(0, 3), ed,
                1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
